// File: rtl/toggle_hs_rx_if.sv
// rtl/toggle_hs_rx_if.sv - toggle handshake and output stream bundle
//
// Purpose: groups the sender-side toggle handshake and the consumer-side
// valid/ready word port of toggle_hs_rx into one bundle.
// Signals:
//   req_tgl    sender request toggle, one transition per word (async to clk)
//   data_in    sender word, stable while a request is outstanding
//   ack_tgl    receiver acknowledge toggle
//   dout       captured word
//   dout_valid dout holds an unconsumed word
//   dout_ready consumer accepts dout
// Modports:
//   master  environment side (sender and consumer)
//   slave   receiver side (toggle_hs_rx)
interface toggle_hs_rx_if #(
  parameter int DATA_W = 8
);
  logic              req_tgl;
  logic [DATA_W-1:0] data_in;
  logic              ack_tgl;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output req_tgl,
    output data_in,
    input  ack_tgl,
    input  dout,
    input  dout_valid,
    output dout_ready
  );

  modport slave (
    input  req_tgl,
    input  data_in,
    output ack_tgl,
    output dout,
    output dout_valid,
    input  dout_ready
  );
endinterface

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - two-phase toggle handshake receiver
//
// Purpose: synchronizes a remote request toggle, captures the sender word and
// offers it on a valid/ready port; flips the acknowledge toggle once the word
// is consumed.
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   hs         toggle_hs_rx_if.slave: req_tgl/data_in in, ack_tgl out,
//              dout/dout_valid out, dout_ready in
//   word_cnt   consumed word count, wraps 255 -> 0
//   proto_err  sticky, sender toggled again before the acknowledge
module toggle_hs_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  toggle_hs_rx_if.slave hs,
  output logic [7:0]    word_cnt,
  output logic          proto_err
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   absorb_q, absorb_d;

  logic req_s;
  logic pending;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = (req_s != ack_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      absorb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      absorb_q <= absorb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], hs.req_tgl};
    ack_d    = ack_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    absorb_d = absorb_q;

    case (state_q)
      IDLE: begin
        if (pending) begin
          if (absorb_q) begin
            // Leftover extra toggle from a violation: answer it with an
            // acknowledge flip so the sender is back in step, but deliver
            // nothing.
            ack_d    = ~ack_q;
            absorb_d = 1'b0;
          end else begin
            dout_d  = hs.data_in;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else begin
          absorb_d = 1'b0;
        end
      end

      HOLD: begin
        if (!pending) begin
          err_d = 1'b1;
        end
        if (valid_q && hs.dout_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
          // Absorb only if the extra toggle was already visible before this
          // accept edge; one arriving exactly on the accept edge is taken as
          // the next word.
          absorb_d = absorb_q & ~pending;
        end else begin
          absorb_d = ~pending;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign hs.ack_tgl    = ack_q;
  assign hs.dout       = dout_q;
  assign hs.dout_valid = valid_q;
  assign word_cnt      = cnt_q;
  assign proto_err     = err_q;

endmodule
